// File: rtl/ncc_pkg.sv
// Shared types, default geometry and saturation helper for the NCC
// descriptor builder.
package ncc_pkg;

  localparam int NCC_PIX_W        = 8;
  localparam int NCC_PATCH_W      = 8;
  localparam int NCC_PATCH_H      = 8;
  localparam int NCC_PIX_PER_BEAT = 4;
  localparam int NCC_INT_BITS     = 6;
  localparam int NCC_FRAC_BITS    = 27;

  localparam int NCC_N      = NCC_PATCH_W * NCC_PATCH_H;
  localparam int NCC_LOG2N  = $clog2(NCC_N);
  localparam int NCC_BEATS  = NCC_N / NCC_PIX_PER_BEAT;
  localparam int NCC_DESC_W = NCC_INT_BITS + NCC_FRAC_BITS;

  typedef logic [NCC_PIX_W-1:0]         pixel_t;
  typedef logic signed [NCC_DESC_W-1:0] desc_elem_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Clamp v to the range of a w-bit two's complement value.
  function automatic logic signed [63:0] sat_desc(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ncc_desc_norm_lane.sv
// One descriptor element: pixel minus patch mean, scaled to the
// descriptor fixed point format and saturated, registered.
module ncc_desc_norm_lane
  import ncc_pkg::*;
#(
  parameter int PIX_W     = NCC_PIX_W,
  parameter int LOG2N     = NCC_LOG2N,
  parameter int FRAC_BITS = NCC_FRAC_BITS,
  parameter int DESC_W    = NCC_DESC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PIX_W-1:0]        pix,
  input  logic [PIX_W+LOG2N-1:0]  sum,
  output logic signed [DESC_W-1:0] elem
);

  localparam int DW = PIX_W + LOG2N + 1;
  localparam int SH = FRAC_BITS - LOG2N;

  logic signed [DW-1:0] d;
  logic signed [63:0]   wide;

  // d is N * (pix - mean), i.e. units of 2^-LOG2N
  assign d = $signed({1'b0, pix, {LOG2N{1'b0}}})
           - $signed({1'b0, sum});

  assign wide = {{(64-DW){d[DW-1]}}, d} <<< SH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elem <= '0;
    end else if (en) begin
      elem <= DESC_W'(sat_desc(wide, DESC_W));
    end
  end

endmodule

// File: rtl/ncc_desc_builder.sv
// Zero-mean NCC descriptor builder: patch fill, mean/variance, normalise.
// Optional NCC_VARIANCE_EN adds the sum-of-squares path and var_out.
module ncc_desc_builder
  import ncc_pkg::*;
#(
  parameter  int PIX_W        = NCC_PIX_W,
  parameter  int PATCH_W      = NCC_PATCH_W,
  parameter  int PATCH_H      = NCC_PATCH_H,
  parameter  int PIX_PER_BEAT = NCC_PIX_PER_BEAT,
  parameter  int INT_BITS     = NCC_INT_BITS,
  parameter  int FRAC_BITS    = NCC_FRAC_BITS,
  localparam int N            = PATCH_W * PATCH_H,
  localparam int LOG2N        = $clog2(N),
  localparam int DESC_W       = INT_BITS + FRAC_BITS,
  localparam int RW           = (PATCH_H > 1) ? $clog2(PATCH_H) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIX_PER_BEAT*PIX_W-1:0] in_data,
  output logic                          desc_valid,
  input  logic                          desc_ready,
  output logic signed [DESC_W-1:0]      desc_out [N],
  output logic [PIX_W+LOG2N-1:0]        mean_out,
  output logic [2*PIX_W+LOG2N-1:0]      var_out,
  output logic [RW-1:0]                 row_cnt
);

  localparam int BEATS = N / PIX_PER_BEAT;
  localparam int BPR   = PATCH_W / PIX_PER_BEAT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
  localparam int SW    = PIX_W + LOG2N;
  localparam int QW    = 2 * PIX_W + LOG2N;

  state_e                  state;
  logic [BW-1:0]           beat_q;
  logic [SW-1:0]           sum_q;
  logic [SW-1:0]           beat_sum;
  logic [PIX_W-1:0]        lane_px [PIX_PER_BEAT];
  logic                    acc;
  logic                    last;
  logic                    calc;

  logic [BEATS-1:0][PIX_PER_BEAT*PIX_W-1:0] buf_q;

  assign in_ready   = (state == FILL);
  assign desc_valid = (state == OUT);
  assign calc       = (state == CALC);
  assign acc        = in_valid && in_ready;
  assign last       = (beat_q == BW'(BEATS - 1));
  assign row_cnt    = RW'(32'(beat_q) / BPR);

  for (genvar g = 0; g < PIX_PER_BEAT; g++) begin : g_lane
    assign lane_px[g] = in_data[(PIX_PER_BEAT-1-g)*PIX_W +: PIX_W];
  end

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < PIX_PER_BEAT; l++) begin
      beat_sum = beat_sum + SW'(lane_px[LW'(l)]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      beat_q   <= '0;
      sum_q    <= '0;
      mean_out <= '0;
    end else begin
      unique case (state)
        FILL: if (acc) begin
          beat_q <= last ? '0 : beat_q + BW'(1);
          sum_q  <= sum_q + beat_sum;
          if (last) state <= CALC;
        end
        CALC: begin
          mean_out <= sum_q;
          state    <= OUT;
        end
        OUT: if (desc_ready) begin
          sum_q <= '0;
          state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  // Pixel storage is data-only; a reset simply restarts the write pointer.
  always_ff @(posedge clk) begin
    if (acc) buf_q[beat_q] <= in_data;
  end

`ifdef NCC_VARIANCE_EN
  logic [QW-1:0]   sumsq_q;
  logic [QW-1:0]   beat_sq;
  logic [QW-1:0]   var_q;
  logic [2*SW-1:0] sum_sq;

  always_comb begin
    beat_sq = '0;
    for (int l = 0; l < PIX_PER_BEAT; l++) begin
      beat_sq = beat_sq + QW'({PIX_W'(0), lane_px[LW'(l)]}
                            * {PIX_W'(0), lane_px[LW'(l)]});
    end
  end

  assign sum_sq  = {SW'(0), sum_q} * {SW'(0), sum_q};
  assign var_out = var_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sumsq_q <= '0;
      var_q   <= '0;
    end else begin
      unique case (state)
        FILL: if (acc) sumsq_q <= sumsq_q + beat_sq;
        CALC: var_q <= sumsq_q - QW'(sum_sq >> LOG2N);
        OUT:  if (desc_ready) sumsq_q <= '0;
        default: ;
      endcase
    end
  end
`else
  assign var_out = '0;
`endif

  for (genvar k = 0; k < N; k++) begin : g_norm
    ncc_desc_norm_lane #(
      .PIX_W     (PIX_W),
      .LOG2N     (LOG2N),
      .FRAC_BITS (FRAC_BITS),
      .DESC_W    (DESC_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (calc),
      .pix  (buf_q[k/PIX_PER_BEAT][(PIX_PER_BEAT-1-k%PIX_PER_BEAT)*PIX_W +: PIX_W]),
      .sum  (sum_q),
      .elem (desc_out[k])
    );
  end

endmodule

// File: tb/tb_ncc_desc_builder.sv
// Randomised self-checking bench for ncc_desc_builder, checked against
// an arithmetic model of mean, N*variance and the zero-mean descriptor.
module tb_ncc_desc_builder;

  localparam int N    = 64;
  localparam int FRAC = 27;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               desc_ready = 1'b0;
  logic [31:0]        in_data = '0;
  logic               in_ready;
  logic               desc_valid;
  logic signed [32:0] desc_out [N];
  logic [13:0]        mean_out;
  logic [21:0]        var_out;
  logic [2:0]         row_cnt;

  int     nvec = 0;
  int     nerr = 0;
  int     pix [N];
  int     pat [4] = '{1, 2, 4, 5};
  longint exp_desc [N];
  longint exp_mean;
  longint exp_var;

  ncc_desc_builder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_out   (desc_out),
    .mean_out   (mean_out),
    .var_out    (var_out),
    .row_cnt    (row_cnt)
  );

  always #5 clk = ~clk;

  // Mean, N*variance and (pixel - mean) * 2^FRAC, clamped to 33 bits.
  task automatic model();
    longint s = 0;
    longint q = 0;
    longint e;
    for (int k = 0; k < N; k++) begin
      s += pix[k];
      q += longint'(pix[k]) * pix[k];
    end
    exp_mean = s;
`ifdef NCC_VARIANCE_EN
    exp_var = q - (s * s) / N;
`else
    exp_var = 0;
`endif
    for (int k = 0; k < N; k++) begin
      e = (longint'(pix[k]) * N - s) * (longint'(1) << FRAC) / N;
      if (e > (longint'(1) << 32) - 1) e = (longint'(1) << 32) - 1;
      if (e < -(longint'(1) << 32)) e = -(longint'(1) << 32);
      exp_desc[k] = e;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    nvec++;
    if (!in_ready) begin
      nerr++;
      $display("FAIL beat_timeout in_ready=%0b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_patch(input int gap_max, output int first_wait);
    int w;
    for (int b = 0; b < N / 4; b++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      send_beat({8'(pix[4*b]), 8'(pix[4*b+1]), 8'(pix[4*b+2]), 8'(pix[4*b+3])}, w);
      if (b == 0) first_wait = w;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_desc();
    int n = 0;
    while (!desc_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (!desc_valid) begin
      nerr++;
      $display("FAIL desc_timeout desc_valid=%0b want 1", desc_valid);
    end
  endtask

  task automatic rand_patch();
    for (int k = 0; k < N; k++) pix[k] = $urandom_range(0, 255);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1 || desc_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_hs ready=%b valid=%b want 1 0", in_ready, desc_valid);
    end
    nvec++;
    if (mean_out !== 14'd0 || var_out !== 22'd0 || row_cnt !== 3'd0) begin
      nerr++;
      $display("FAIL reset_regs mean=%0d var=%0d row=%0d want 0 0 0",
               mean_out, var_out, row_cnt);
    end
    for (int k = 0; k < N; k++) begin
      nvec++;
      if (desc_out[k] !== 33'sd0) begin
        nerr++;
        $display("FAIL reset_desc[%0d] got %0d want 0", k, desc_out[k]);
      end
    end
  endtask

  task automatic test_constant();
    int w;
    for (int k = 0; k < N; k++) pix[k] = 7;
    model();
    send_patch(0, w);
    nvec++;
    if (desc_valid !== 1'b0) begin
      nerr++;
      $display("FAIL const_lat1 desc_valid=%b want 0", desc_valid);
    end
    @(negedge clk);
    nvec++;
    if (desc_valid !== 1'b1) begin
      nerr++;
      $display("FAIL const_lat2 desc_valid=%b want 1", desc_valid);
    end
    nvec++;
    if (mean_out !== 14'd448 || var_out !== exp_var) begin
      nerr++;
      $display("FAIL const_mv mean=%0d var=%0d want 448 %0d", mean_out, var_out, exp_var);
    end
    for (int k = 0; k < N; k++) begin
      nvec++;
      if (desc_out[k] !== exp_desc[k]) begin
        nerr++;
        $display("FAIL const_desc[%0d] got %0d want %0d", k, desc_out[k], exp_desc[k]);
      end
    end
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
    nvec++;
    if (desc_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL const_hs valid=%b ready=%b want 0 1", desc_valid, in_ready);
    end
  endtask

  task automatic test_ramp();
    int w;
    for (int k = 0; k < N; k++) pix[k] = pat[k % 4];
    model();
    send_patch(2, w);
    wait_desc();
    nvec++;
    if (mean_out !== 14'd192 || var_out !== exp_var) begin
      nerr++;
      $display("FAIL ramp_mv mean=%0d var=%0d want 192 %0d", mean_out, var_out, exp_var);
    end
    for (int k = 0; k < N; k++) begin
      nvec++;
      if (desc_out[k] !== exp_desc[k]) begin
        nerr++;
        $display("FAIL ramp_desc[%0d] got %0d want %0d", k, desc_out[k], exp_desc[k]);
      end
    end
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int w;
    for (int k = 0; k < N; k++) pix[k] = 0;
    pix[0] = 255;
    model();
    send_patch(1, w);
    wait_desc();
    nvec++;
    if (mean_out !== 14'd255 || var_out !== exp_var) begin
      nerr++;
      $display("FAIL sat_mv mean=%0d var=%0d want 255 %0d", mean_out, var_out, exp_var);
    end
    for (int k = 0; k < N; k++) begin
      nvec++;
      if (desc_out[k] !== exp_desc[k]) begin
        nerr++;
        $display("FAIL sat_desc[%0d] got %0d want %0d", k, desc_out[k], exp_desc[k]);
      end
    end
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int w;
    rand_patch();
    model();
    send_patch(2, w);
    wait_desc();
    in_valid = 1'b1;
    in_data  = $urandom;
    for (int c = 0; c < 5; c++) begin
      nvec++;
      if (desc_valid !== 1'b1 || in_ready !== 1'b0 || row_cnt !== 3'd0) begin
        nerr++;
        $display("FAIL bp_hold valid=%b ready=%b row=%0d want 1 0 0",
                 desc_valid, in_ready, row_cnt);
      end
      nvec++;
      if (mean_out !== exp_mean || var_out !== exp_var) begin
        nerr++;
        $display("FAIL bp_mv mean=%0d var=%0d want %0d %0d",
                 mean_out, var_out, exp_mean, exp_var);
      end
      for (int k = 0; k < N; k++) begin
        nvec++;
        if (desc_out[k] !== exp_desc[k]) begin
          nerr++;
          $display("FAIL bp_desc[%0d] got %0d want %0d", k, desc_out[k], exp_desc[k]);
        end
      end
      @(negedge clk);
      in_data = $urandom;
    end
    in_valid   = 1'b0;
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
    nvec++;
    if (desc_valid !== 1'b0 || in_ready !== 1'b1 || row_cnt !== 3'd0) begin
      nerr++;
      $display("FAIL bp_release valid=%b ready=%b row=%0d want 0 1 0",
               desc_valid, in_ready, row_cnt);
    end
    rand_patch();
    model();
    send_patch(0, w);
    wait_desc();
    for (int k = 0; k < N; k++) begin
      nvec++;
      if (desc_out[k] !== exp_desc[k]) begin
        nerr++;
        $display("FAIL bp_next[%0d] got %0d want %0d", k, desc_out[k], exp_desc[k]);
      end
    end
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    for (int b = 0; b < 7; b++) send_beat($urandom, w);
    in_valid = 1'b0;
    nvec++;
    if (row_cnt !== 3'd3) begin
      nerr++;
      $display("FAIL rst_pre row=%0d want 3", row_cnt);
    end
    #2 rst = 1'b0;
    #2;
    nvec++;
    if (row_cnt !== 3'd0 || in_ready !== 1'b1 || desc_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_mid row=%0d ready=%b valid=%b want 0 1 0",
               row_cnt, in_ready, desc_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) pix[k] = pat[k % 4];
    model();
    send_patch(0, w);
    wait_desc();
    nvec++;
    if (mean_out !== 14'd192 || var_out !== exp_var) begin
      nerr++;
      $display("FAIL rst_mv mean=%0d var=%0d want 192 %0d", mean_out, var_out, exp_var);
    end
    for (int k = 0; k < N; k++) begin
      nvec++;
      if (desc_out[k] !== exp_desc[k]) begin
        nerr++;
        $display("FAIL rst_desc[%0d] got %0d want %0d", k, desc_out[k], exp_desc[k]);
      end
    end
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w;
    desc_ready = 1'b1;
    rand_patch();
    model();
    send_patch(0, w);
    @(negedge clk);
    nvec++;
    if (desc_valid !== 1'b1 || mean_out !== exp_mean) begin
      nerr++;
      $display("FAIL b2b_a valid=%b mean=%0d want 1 %0d", desc_valid, mean_out, exp_mean);
    end
    for (int k = 0; k < N; k++) begin
      nvec++;
      if (desc_out[k] !== exp_desc[k]) begin
        nerr++;
        $display("FAIL b2b_a_desc[%0d] got %0d want %0d", k, desc_out[k], exp_desc[k]);
      end
    end
    rand_patch();
    model();
    send_patch(0, w);
    nvec++;
    if (w !== 1) begin
      nerr++;
      $display("FAIL b2b_restart waits=%0d want 1", w);
    end
    @(negedge clk);
    nvec++;
    if (desc_valid !== 1'b1 || mean_out !== exp_mean || var_out !== exp_var) begin
      nerr++;
      $display("FAIL b2b_b valid=%b mean=%0d var=%0d want 1 %0d %0d",
               desc_valid, mean_out, var_out, exp_mean, exp_var);
    end
    for (int k = 0; k < N; k++) begin
      nvec++;
      if (desc_out[k] !== exp_desc[k]) begin
        nerr++;
        $display("FAIL b2b_b_desc[%0d] got %0d want %0d", k, desc_out[k], exp_desc[k]);
      end
    end
    @(negedge clk);
    desc_ready = 1'b0;
  endtask

  task automatic test_random();
    int w;
    for (int r = 0; r < 5; r++) begin
      rand_patch();
      model();
      send_patch(3, w);
      wait_desc();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      nvec++;
      if (desc_valid !== 1'b1 || mean_out !== exp_mean || var_out !== exp_var) begin
        nerr++;
        $display("FAIL rnd%0d_mv valid=%b mean=%0d var=%0d want 1 %0d %0d",
                 r, desc_valid, mean_out, var_out, exp_mean, exp_var);
      end
      for (int k = 0; k < N; k++) begin
        nvec++;
        if (desc_out[k] !== exp_desc[k]) begin
          nerr++;
          $display("FAIL rnd%0d_desc[%0d] got %0d want %0d",
                   r, k, desc_out[k], exp_desc[k]);
        end
      end
      desc_ready = 1'b1;
      @(negedge clk);
      desc_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
